exe_fwd_ctrl: RTL and testbench
===============================

EXE_FWD_CTRL -- requirements
Module: exe_fwd_ctrl

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, the register-address width.
REQ-002 The block SHALL have parameter CNT_W, default 16, the stall-counter width.
REQ-003 Port clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1, is the reset: synchronous and active-high.
REQ-005 Port id_valid, input, 1, SHALL indicate a valid instruction in ID.
REQ-006 Ports rs1_addr and rs2_addr, input, REG_AW each, SHALL carry the ID source registers.
REQ-007 Ports rs1_used and rs2_used, input, 1 each, SHALL indicate that the matching source is read.
REQ-008 Ports rd_addr (input, REG_AW) and reg_write (input, 1) SHALL carry the ID destination and its write enable.
REQ-009 Port op_type, input, 2, SHALL carry the ID result class: 00 ALU, 01 MEM load, 10 VDOT, 11 reserved (treated as ALU).
REQ-010 Port stall, output, 1, SHALL hold ID and the front end; it is combinational.
REQ-011 Port issue, output, 1, SHALL equal id_valid & ~stall.
REQ-012 Ports fwd_sel_rs1 and fwd_sel_rs2, output, 2 each, SHALL select the operand source: 0 regfile, 1 slot0/EXE, 2 slot1, 3 slot2.
REQ-013 Port slot_valid, output, 3, SHALL show the valid bits of the in-flight tracking slots.
REQ-014 Port stall_cnt, output, CNT_W, SHALL count stall cycles and saturate at all-ones.

Function
REQ-015 The block SHALL track 3 slots {valid, rd, reg_write, op}; slot0 is EXE, slot1 is one cycle later, slot2 is two cycles later.
REQ-016 Every cycle, slot2<=slot1 and slot1<=slot0; the downstream pipe SHALL never stall.
REQ-017 slot0 SHALL load the ID fields with valid=1 when issue=1; otherwise it SHALL load a bubble (all fields 0).
REQ-018 A slot SHALL match a source when it is valid, has reg_write=1, rd==rs, rs!=0, and the source's used bit is 1.
REQ-019 Only the youngest matching slot (lowest index) SHALL be considered per source; older matches are ignored.
REQ-020 Data readiness SHALL be: ALU ready in slot>=0; MEM ready in slot>=1; VDOT ready only in slot2.
REQ-021 If the youngest match is ready, fwd_sel SHALL be slot index+1; if no match, fwd_sel SHALL be 0.
REQ-022 stall SHALL be 1 when id_valid=1 and any used source's youngest match is not ready.
REQ-023 While stall=1, fwd_sel values are don't-care and SHALL be driven 0.
REQ-024 Resulting stall lengths SHALL be: MEM in slot0 gives 1 stall cycle; VDOT in slot0 gives 2; VDOT in slot1 gives 1.
REQ-025 The regfile write happens at the end of the slot2 cycle, so a producer that has left slot2 SHALL yield fwd_sel=0.
REQ-026 rs1 and rs2 SHALL be evaluated independently; stall is the OR of both sources.
REQ-027 stall_cnt SHALL increment on each cycle with stall=1 and hold at 2^CNT_W-1.

Reset
REQ-028 While rst=1 at a clock edge, all slots, slot_valid and stall_cnt SHALL clear to 0.
REQ-029 Immediately after reset, stall=0, fwd_sel_rs1=0 and fwd_sel_rs2=0.
REQ-030 A reset asserted mid-stall SHALL drop in-flight producers, so stall deasserts the next cycle.

Configuration
REQ-031 Macro EXE_FWD_EN defined SHALL enable forwarding per REQ-019..REQ-024.
REQ-032 With EXE_FWD_EN undefined, any matching slot SHALL cause a stall, fwd_sel SHALL be tied to 0, and the readiness logic SHALL be removed.

Structure
REQ-033 A shared package SHALL hold the op_type encodings (OP_ALU, OP_MEM, OP_VDOT), the FWD_* select encodings and the per-op readiness-slot constants.
REQ-034 A single sub-module, exe_fwd_match, SHALL compute youngest-match, fwd_sel and not-ready for one source; it is instantiated twice.

Verification
REQ-035 Sequence: ALU writes x5, then next instruction reads rs1=x5 -> stall=0, fwd_sel_rs1=1.
REQ-036 Sequence: MEM load writes x7, then next instruction reads rs2=x7 -> stall=1 for exactly 1 cycle, then fwd_sel_rs2=2 and issue=1.
REQ-037 Sequence: VDOT writes x9, then next instruction reads x9 -> stall for 2 cycles, then fwd_sel=3, and stall_cnt increases by 2.
REQ-038 Sequence: ALU writes x3, then ALU writes x3 again, then a reader of x3 -> fwd_sel=1 (youngest match), not 2.
REQ-039 Cases: rd=x0 with reg_write=1 followed by a reader of x0, and a reader with rs1_used=0 -> stall=0 and fwd_sel=0.
REQ-040 Sequence: rst pulsed during a VDOT stall -> next cycle stall=0, slot_valid=000, stall_cnt=0; also rerun REQ-035 with EXE_FWD_EN undefined -> 3-cycle stall, fwd_sel=0.

Source files
------------

// File: rtl/exe_fwd_ctrl_pkg.sv
// Shared encodings for the EXE forwarding/interlock controller: result classes,
// operand-select codes and the slot in which each result class becomes forwardable.
package exe_fwd_ctrl_pkg;

    localparam int NUM_SLOTS = 3;

    typedef enum logic [1:0] {
        OP_ALU  = 2'b00,
        OP_MEM  = 2'b01,
        OP_VDOT = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    localparam logic [1:0] FWD_RF = 2'd0;
    localparam logic [1:0] FWD_S0 = 2'd1;
    localparam logic [1:0] FWD_S1 = 2'd2;
    localparam logic [1:0] FWD_S2 = 2'd3;

    // Lowest slot index at which a result of each class can be forwarded.
    localparam logic [1:0] RDY_ALU  = 2'd0;
    localparam logic [1:0] RDY_MEM  = 2'd1;
    localparam logic [1:0] RDY_VDOT = 2'd2;

    // The reserved class behaves like ALU.
    function automatic logic [1:0] rdy_slot(input logic [1:0] op);
        case (op)
            OP_MEM:  rdy_slot = RDY_MEM;
            OP_VDOT: rdy_slot = RDY_VDOT;
            default: rdy_slot = RDY_ALU;
        endcase
    endfunction

endpackage

// File: rtl/exe_fwd_match.sv
// Per-source hazard check against the in-flight slots: youngest match, operand
// select and not-ready flag. EXE_FWD_EN enables forwarding; otherwise any match stalls.
module exe_fwd_match
    import exe_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0]                 rs,
    input  logic                              used,
    input  logic [NUM_SLOTS-1:0]              slot_vld,
    input  logic [NUM_SLOTS-1:0]              slot_we,
    input  logic [NUM_SLOTS-1:0][REG_AW-1:0]  slot_rd,
    input  logic [NUM_SLOTS-1:0][1:0]         slot_op,
    output logic [1:0]                        fwd_sel,
    output logic                              not_ready
);

    logic [NUM_SLOTS-1:0] hit;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            hit[i] = slot_vld[i] & slot_we[i] & (slot_rd[i] == rs) & (rs != '0) & used;
        end
    end

`ifdef EXE_FWD_EN
    logic       found;
    logic [1:0] idx;
    logic       ready;

    // Scan oldest to youngest so the lowest-index hit wins.
    always_comb begin
        found = 1'b0;
        idx   = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (hit[i]) begin
                found = 1'b1;
                idx   = 2'(i);
            end
        end
        ready     = (idx >= rdy_slot(slot_op[idx]));
        not_ready = found & ~ready;
        fwd_sel   = (found & ready) ? 2'(idx + 2'd1) : FWD_RF;
    end
`else
    always_comb begin
        not_ready = |hit;
        fwd_sel   = FWD_RF;
    end
`endif

endmodule

// File: rtl/exe_fwd_ctrl.sv
// EXE forwarding and load/VDOT interlock controller tracking three in-flight
// producers. Build with EXE_FWD_EN to forward; without it every RAW hazard stalls.
module exe_fwd_ctrl
    import exe_fwd_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic              reg_write,
    input  logic [1:0]        op_type,
    output logic              stall,
    output logic              issue,
    output logic [1:0]        fwd_sel_rs1,
    output logic [1:0]        fwd_sel_rs2,
    output logic [2:0]        slot_valid,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [NUM_SLOTS-1:0]             vld_pipe;
    logic [NUM_SLOTS-1:0]             slot_we;
    logic [NUM_SLOTS-1:0][REG_AW-1:0] slot_rd;
    logic [NUM_SLOTS-1:0][1:0]        slot_op;

    logic [1:0] sel1, sel2;
    logic       nr1, nr2;

    exe_fwd_match #(.REG_AW(REG_AW)) u_match_rs1 (
        .rs        (rs1_addr),
        .used      (rs1_used),
        .slot_vld  (vld_pipe),
        .slot_we   (slot_we),
        .slot_rd   (slot_rd),
        .slot_op   (slot_op),
        .fwd_sel   (sel1),
        .not_ready (nr1)
    );

    exe_fwd_match #(.REG_AW(REG_AW)) u_match_rs2 (
        .rs        (rs2_addr),
        .used      (rs2_used),
        .slot_vld  (vld_pipe),
        .slot_we   (slot_we),
        .slot_rd   (slot_rd),
        .slot_op   (slot_op),
        .fwd_sel   (sel2),
        .not_ready (nr2)
    );

    always_comb begin
        stall       = id_valid & (nr1 | nr2);
        issue       = id_valid & ~stall;
        fwd_sel_rs1 = stall ? FWD_RF : sel1;
        fwd_sel_rs2 = stall ? FWD_RF : sel2;
        slot_valid  = vld_pipe;
    end

    // Downstream never stalls: slots shift every cycle, slot0 takes a bubble unless issuing.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            slot_we   <= '0;
            slot_rd   <= '0;
            slot_op   <= '0;
            stall_cnt <= '0;
        end else begin
            vld_pipe <= {vld_pipe[NUM_SLOTS-2:0], issue};
            slot_we  <= {slot_we[NUM_SLOTS-2:0], issue & reg_write};
            slot_rd  <= {slot_rd[NUM_SLOTS-2:0], issue ? rd_addr : {REG_AW{1'b0}}};
            slot_op  <= {slot_op[NUM_SLOTS-2:0], issue ? op_type : 2'b00};
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exe_fwd_ctrl.sv
// Scoreboard bench for exe_fwd_ctrl; expectations follow the EXE_FWD_EN build setting.
module tb_exe_fwd_ctrl;
    import exe_fwd_ctrl_pkg::*;

`ifdef EXE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
    logic       rs1_used = 1'b0, rs2_used = 1'b0, reg_write = 1'b0;
    logic [1:0] op_type = '0;

    logic        stall, issue;
    logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
    logic [2:0]  slot_valid;
    logic [15:0] stall_cnt;

    logic        stall_b, issue_b;
    logic [1:0]  fwd1_b, fwd2_b;
    logic [2:0]  sv_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    exe_fwd_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_addr(rd_addr), .reg_write(reg_write), .op_type(op_type),
        .stall(stall), .issue(issue),
        .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2),
        .slot_valid(slot_valid), .stall_cnt(stall_cnt)
    );

    // Narrow counter instance so saturation is reached within the run.
    exe_fwd_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_used(rs1_used), .rs2_used(rs2_used),
        .rd_addr(rd_addr), .reg_write(reg_write), .op_type(op_type),
        .stall(stall_b), .issue(issue_b),
        .fwd_sel_rs1(fwd1_b), .fwd_sel_rs2(fwd2_b),
        .slot_valid(sv_b), .stall_cnt(cnt_b)
    );

    typedef struct {
        logic       stall;
        logic       issue;
        logic [1:0] f1;
        logic [1:0] f2;
        logic [2:0] sv;
        int         cnt;
        int         cnt2;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic [2:0] sv_m;
    int         cnt_m;
    int         cnt2_m;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("stall",       int'(stall),       int'(me.stall));
            chk("issue",       int'(issue),       int'(me.issue));
            chk("fwd_sel_rs1", int'(fwd_sel_rs1), int'(me.f1));
            chk("fwd_sel_rs2", int'(fwd_sel_rs2), int'(me.f2));
            chk("slot_valid",  int'(slot_valid),  int'(me.sv));
            chk("stall_cnt",   int'(stall_cnt),   me.cnt);
            chk("stall_cnt_sat", int'(cnt_b),     me.cnt2);
            cyc++;
        end
    end

    // Drive one ID cycle with its hand-derived stall/fwd result; slot and counter
    // expectations advance with the issue/stall decision just stated.
    task automatic step(input logic r, input logic v,
                        input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2,
                        input logic [4:0] d, input logic we, input logic [1:0] op,
                        input logic es, input logic [1:0] ef1, input logic [1:0] ef2);
        exp_t e;
        rst = r; id_valid = v;
        rs1_addr = a1; rs1_used = u1; rs2_addr = a2; rs2_used = u2;
        rd_addr = d; reg_write = we; op_type = op;
        e.stall = es; e.issue = v & ~es; e.f1 = ef1; e.f2 = ef2;
        e.sv = sv_m; e.cnt = cnt_m; e.cnt2 = cnt2_m;
        q.push_back(e);
        if (r) begin
            sv_m = '0; cnt_m = 0; cnt2_m = 0;
        end else begin
            sv_m = {sv_m[1:0], v & ~es};
            if (es && cnt_m < 65535) cnt_m++;
            if (es && cnt2_m < 3) cnt2_m++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic prod(input logic [1:0] op, input logic [4:0] d);
        step(0, 1, 0, 0, 0, 0, d, 1, op, 0, 0, 0);
    endtask

    task automatic rd(input logic r, input logic [4:0] a1, input logic u1,
                      input logic [4:0] a2, input logic u2,
                      input logic es, input logic [1:0] ef1, input logic [1:0] ef2);
        step(r, 1, a1, u1, a2, u2, 0, 0, 2'd0, es, ef1, ef2);
    endtask

    initial begin
        sv_m = '0; cnt_m = 0; cnt2_m = 0;
        @(posedge clk);
        #1;
        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0, 2'd0, 0, 0, 0);

        // ALU x5 -> rs1 reader
        prod(OP_ALU, 5);
        for (int k = 0; k < (FWD ? 0 : 3); k++) rd(0, 5, 1, 0, 0, 1, 0, 0);
        rd(0, 5, 1, 0, 0, 0, FWD ? 2'd1 : 2'd0, 0);
        repeat (3) idle();

        // MEM x7 -> rs2 reader
        prod(OP_MEM, 7);
        for (int k = 0; k < (FWD ? 1 : 3); k++) rd(0, 0, 0, 7, 1, 1, 0, 0);
        rd(0, 0, 0, 7, 1, 0, 0, FWD ? 2'd2 : 2'd0);
        repeat (3) idle();

        // VDOT x9 -> reader on both sources
        prod(OP_VDOT, 9);
        for (int k = 0; k < (FWD ? 2 : 3); k++) rd(0, 9, 1, 9, 1, 1, 0, 0);
        rd(0, 9, 1, 9, 1, 0, FWD ? 2'd3 : 2'd0, FWD ? 2'd3 : 2'd0);
        repeat (3) idle();

        // Two writers of x3: youngest wins
        prod(OP_ALU, 3);
        prod(OP_ALU, 3);
        for (int k = 0; k < (FWD ? 0 : 3); k++) rd(0, 3, 1, 0, 0, 1, 0, 0);
        rd(0, 3, 1, 0, 0, 0, FWD ? 2'd1 : 2'd0, 0);
        repeat (3) idle();

        // x0 writer never matches; unused sources never match
        prod(OP_ALU, 0);
        rd(0, 0, 1, 0, 1, 0, 0, 0);
        prod(OP_ALU, 6);
        rd(0, 6, 0, 6, 0, 0, 0, 0);
        repeat (3) idle();

        // Reset in the middle of a VDOT stall
        prod(OP_VDOT, 9);
        rd(0, 9, 1, 0, 0, 1, 0, 0);
        rd(1, 9, 1, 0, 0, 1, 0, 0);
        rd(0, 9, 1, 0, 0, 0, 0, 0);
        idle();

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
